// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO for pixel/feature streams between pipeline
// stages, valid/ready on both sides.
//
// Read modes (FWFT parameter):
//   FWFT=1  first-word-fall-through. An output register prefetches the
//           memory head and m_valid/m_data present it. The output register
//           counts toward level and capacity.
//   FWFT=0  standard read. m_ready is a read request. m_valid pulses for one
//           cycle with the word in m_data, and m_data holds afterwards.
//
// Optional statistics: define FIFO_STATS_EN to enable peak_level and
// drop_count. When it is undefined, both ports read 0 and no counter logic
// exists.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous clear of contents, flags and statistics
//   s_valid/s_ready     write handshake (s_ready registered, = !full)
//   s_data              write payload
//   m_valid/m_ready     read handshake (meaning depends on FWFT)
//   m_data              read payload
//   level               entries held
//   almost_full         level >= AFULL_THRESH
//   almost_empty        level <= AEMPTY_THRESH
//   overflow            sticky: write attempted while s_ready=0
//   underflow           sticky: standard-mode read attempted while empty
//   peak_level          maximum level since reset/flush (stats build only)
//   drop_count          saturating count of dropped writes (stats build only)
module stream_fifo #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 1024,
  parameter int ADDR_WIDTH    = 10,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   peak_level,
  output logic [15:0]           drop_count
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]         DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0]         AFULL_L  = LW'(AFULL_THRESH);
  localparam logic [LW-1:0]         AEMPTY_L = LW'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : g_addr_chk
    $error("stream_fifo: ADDR_WIDTH too small for DEPTH");
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  s_ready_q, afull_q, aempty_q;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  wr_acc, drop, rd_mem, lvl_dec;
  logic [LW-1:0]         mem_cnt;

  always_comb begin
    wr_acc    = s_valid && s_ready_q;
    drop      = s_valid && !s_ready_q;
    rd_mem    = 1'b0;
    lvl_dec   = 1'b0;
    mem_cnt   = level_q;
    udf_d     = udf_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (FWFT != 0) begin
      // The output register is part of level; the memory holds the rest.
      // Refill the output register whenever it is empty or being popped.
      mem_cnt = level_q - LW'(m_valid_q);
      lvl_dec = m_valid_q && m_ready;
      rd_mem  = (mem_cnt != '0) && (!m_valid_q || lvl_dec);
      if (rd_mem) begin
        m_valid_d = 1'b1;
      end else if (lvl_dec) begin
        m_valid_d = 1'b0;
      end
    end else begin
      rd_mem    = m_ready && (level_q != '0);
      lvl_dec   = rd_mem;
      m_valid_d = rd_mem;
      if (m_ready && (level_q == '0)) begin
        udf_d = 1'b1;
      end
    end

    if (rd_mem) begin
      m_data_d = mem_q[rd_ptr_q];
    end

    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_mem ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q + LW'(wr_acc) - LW'(lvl_dec);
    ovf_d    = ovf_q | drop;

    // Flush wins over any same-cycle write or read; m_data keeps its value.
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
  end

  // ---- stage p0: state and registered status ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= (level_d != DEPTH_L);
      afull_q   <= (level_d >= AFULL_L);
      aempty_q  <= (level_d <= AEMPTY_L);
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign level        = level_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef FIFO_STATS_EN
  logic [LW-1:0] peak_q, peak_d;
  logic [15:0]   drop_q, drop_d;

  always_comb begin
    peak_d = (level_d > peak_q) ? level_d : peak_q;
    drop_d = drop ? sat_inc16(drop_q) : drop_q;
    if (flush) begin
      peak_d = '0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
      drop_q <= '0;
    end else begin
      peak_q <= peak_d;
      drop_q <= drop_d;
    end
  end

  assign peak_level = peak_q;
  assign drop_count = drop_q;
`else
  assign peak_level = '0;
  assign drop_count = '0;
`endif

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Parametrised successor to the team's basic synchronous FIFO.
- Carries pixel and feature streams between GAN pipeline stages over a valid/ready handshake.
- Selectable first-word-fall-through (FWFT) or standard read mode.
- Programmable almost-full and almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 16, payload width in bits
DEPTH, 1024, total capacity in entries (memory plus FWFT output register)
ADDR_WIDTH, 10, pointer width; must satisfy 2**ADDR_WIDTH >= DEPTH (simulation-only $error otherwise)
FWFT, 1, 1 = first-word-fall-through, 0 = standard registered read
AFULL_THRESH, DEPTH-4, almost_full asserts when level >= this value
AEMPTY_THRESH, 4, almost_empty asserts when level <= this value

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  synchronous clear of contents and error flags
s_valid  in  1  write request
s_ready  out  1  FIFO can accept a write (registered, = !full)
s_data  in  DATA_WIDTH  write data
m_valid  out  1  FWFT: head valid; standard: one-cycle read-data strobe
m_ready  in  1  FWFT: consume head; standard: read request
m_data  out  DATA_WIDTH  read data
level  out  ADDR_WIDTH+1  entries held
almost_full  out  1  level >= AFULL_THRESH
almost_empty  out  1  level <= AEMPTY_THRESH
overflow  out  1  sticky: write attempted while !s_ready
underflow  out  1  sticky: standard-mode read attempted while empty
peak_level  out  ADDR_WIDTH+1  statistics; see Optional Feature
drop_count  out  16  statistics; see Optional Feature

Behaviour:
- Reset values (async): pointers 0, level 0, s_ready 1, m_valid 0, m_data 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, peak_level 0, drop_count 0.
- Write accepted iff s_valid && s_ready.
  - s_valid && !s_ready: data dropped, overflow set.
  - At full, a same-cycle pop does not admit a write; s_ready rises the following cycle.
- Pointers wrap from DEPTH-1 to 0. Non-power-of-two DEPTH must work.
- level, s_ready, almost_full and almost_empty are registered from next-state level; they reflect the current edge's accepted writes and reads.
  - Simultaneous accepted write and read: level unchanged.
- FWFT=1:
  - One output register prefetches the memory head.
  - Write into an empty FIFO at edge N gives m_valid=1 with that data after edge N+1 (2-cycle first-word latency).
  - Pop occurs on m_valid && m_ready. The next entry is presented the cycle after the pop, giving a 1-entry/cycle sustained rate.
  - m_valid and m_data stay stable while m_ready=0.
  - m_ready with m_valid=0 is ignored and is not an error.
  - level counts the output register.
- FWFT=0:
  - m_ready && !empty at edge N gives m_valid=1 for exactly one cycle after edge N, with data in m_data.
  - m_data holds its value afterwards.
  - m_ready while empty sets underflow and does not move pointers.
- flush:
  - Takes priority over same-cycle write and read.
  - Next cycle: level 0, m_valid 0, s_ready 1, overflow 0, underflow 0, statistics 0.
  - m_data is not cleared.
- Reset asserted mid-transfer returns all state to reset values immediately. In-flight data is lost.

Optional Feature:
Macro FIFO_STATS_EN.
- Defined:
  - peak_level tracks the maximum level since reset or flush.
  - drop_count increments on each dropped write and saturates at 16'hFFFF.
- Undefined: both ports are present but tied to 0, and no counter logic is generated.

Test Plan:
- DEPTH=8, FWFT=1: write 0x11..0x18 back-to-back with m_ready=0 -> s_ready=0 after the 8th write; level=8; almost_full=1 at level 4 (AFULL_THRESH=4); read out with m_ready=1 -> 0x11..0x18 in order; level returns to 0.
- FWFT=1, single write 0xABCD into empty FIFO at edge N -> m_valid=1 and m_data=0xABCD after edge N+1; level=1 after edge N.
- FWFT=0, DEPTH=8: fill 3 entries; m_ready held 4 cycles -> three single-cycle m_valid pulses with data in order; 4th request sets underflow=1; level=0.
- DEPTH=5 (non-power-of-two), continuous write+read for 20 cycles -> pointer wrap; all 20 values in order; level constant.
- Full FIFO with s_valid=1 for 3 cycles -> overflow=1; contents unchanged; FIFO_STATS_EN: drop_count=3, peak_level=DEPTH.
- Mid-stream flush with concurrent s_valid and m_ready -> next cycle level=0, m_valid=0, overflow=0; flushed write not stored. Async rst pulse mid-stream -> all outputs at reset values before the next clock edge.
